riscv_operand_fetch: RTL and testbench

- Operand-fetch stage directly upstream of the ALU.
- Accepts a 32-bit RV32I instruction word and reads rs1/rs2 from an internal 32x32 register file.
- Presents the instruction word and both operand values to the ALU from a single pipeline register, using a valid/ready handshake.
- Takes the write-back port from the downstream stage, with same-cycle bypass and refresh of held operands.

---
 rtl/riscv_operand_fetch.sv | 121 ++++++++++++
 tb/tb_riscv_operand_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/riscv_operand_fetch.sv
// Operand-fetch stage feeding the ALU: decodes rs1/rs2, reads the 32x32
// register file with write-back bypass, and holds instruction + operands
// in a single valid/ready pipeline register.
// Optional build macro RF_RESET_CLEAR_EN: reset also clears x1..x31.
module riscv_operand_fetch #(
    parameter int unsigned XLEN   = 32,
    parameter logic [31:0] NOP_IW = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     iw_in,
    input  logic            iw_valid_in,
    output logic            iw_ready_out,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [31:0]     iw_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic            out_valid,
    input  logic            out_ready_in
);

    // Entry 0 is never written, so x0 is handled purely by the read mux.
    logic [XLEN-1:0] rf_q [32];

    logic            valid_q, valid_d;
    logic [31:0]     iw_q, iw_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    logic [4:0]      rs1_idx, rs2_idx;
    logic [4:0]      held_rs1, held_rs2;
    logic [XLEN-1:0] rs1_rd, rs2_rd;
    logic            accept;
    logic            wb_live;

    assign rs1_idx  = iw_in[19:15];
    assign rs2_idx  = iw_in[24:20];
    assign held_rs1 = iw_q[19:15];
    assign held_rs2 = iw_q[24:20];
    assign wb_live  = wb_en && (wb_addr != 5'd0);

    assign iw_ready_out = !valid_q || out_ready_in;
    assign accept       = iw_valid_in && iw_ready_out;

    // Register-file read with write-first bypass from the write-back port
    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if (rs1_idx != 5'd0) begin
            rs1_rd = (wb_en && wb_addr == rs1_idx) ? wb_data : rf_q[rs1_idx];
        end
        if (rs2_idx != 5'd0) begin
            rs2_rd = (wb_en && wb_addr == rs2_idx) ? wb_data : rf_q[rs2_idx];
        end
    end

    // Register-file write; reset blocks writes so reset always dominates
`ifdef RF_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset && wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end
`endif

    // Next state of the output register: accept, else drain, else stall-refresh
    always_comb begin
        valid_d = valid_q;
        iw_d    = iw_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (accept) begin
            valid_d = 1'b1;
            iw_d    = iw_in;
            rs1_d   = rs1_rd;
            rs2_d   = rs2_rd;
        end else if (valid_q && out_ready_in) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (wb_live && wb_addr == held_rs1) begin
                rs1_d = wb_data;
            end
            if (wb_live && wb_addr == held_rs2) begin
                rs2_d = wb_data;
            end
        end
    end

    // Output pipeline register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            iw_q    <= NOP_IW;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            iw_q    <= iw_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    assign out_valid    = valid_q;
    assign iw_out       = iw_q;
    assign rs1_data_out = rs1_q;
    assign rs2_data_out = rs2_q;

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Directed bench for riscv_operand_fetch with a reference register-file
// model and an expected-transaction queue checked every cycle.
module tb_riscv_operand_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iw_in;
    logic        iw_valid_in;
    logic        iw_ready_out;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] iw_out;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic        out_valid;
    logic        out_ready_in;

    always #5 clk = ~clk;

    riscv_operand_fetch #(.XLEN(32), .NOP_IW(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .iw_in        (iw_in),
        .iw_valid_in  (iw_valid_in),
        .iw_ready_out (iw_ready_out),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .iw_out       (iw_out),
        .rs1_data_out (rs1_data_out),
        .rs2_data_out (rs2_data_out),
        .out_valid    (out_valid),
        .out_ready_in (out_ready_in)
    );

    typedef struct {
        logic [31:0] iw;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    item_t       exp_q[$];
    item_t       last_out;
    item_t       tmp;
    logic [31:0] rf_m [32];
    logic        rdy_m;
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] rd_m(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf_m[idx];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        return {7'h00, r2, r1, 3'b000, rd, 7'h33};
    endfunction

    // Reference model, evaluated on the pre-edge input values
    always @(posedge clk) begin
        if (!reset) begin
            exp_q.delete();
            last_out = '{NOP, 32'h0, 32'h0};
`ifdef RF_RESET_CLEAR_EN
            for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
`endif
        end else begin
            rdy_m = (exp_q.size() == 0) || out_ready_in;
            if (exp_q.size() > 0 && out_ready_in) begin
                last_out = exp_q.pop_front();
            end else if (exp_q.size() > 0 && wb_en && wb_addr != 5'd0) begin
                tmp = exp_q[0];
                if (tmp.iw[19:15] == wb_addr) tmp.a = wb_data;
                if (tmp.iw[24:20] == wb_addr) tmp.b = wb_data;
                exp_q[0] = tmp;
            end
            if (iw_valid_in && rdy_m)
                exp_q.push_back('{iw_in, rd_m(iw_in[19:15]), rd_m(iw_in[24:20])});
            if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check ready against current inputs, then outputs after the edge
    task automatic step();
        item_t cur;
        #1;
        chk("iw_ready_out", {31'h0, iw_ready_out}, {31'h0, (exp_q.size() == 0) || out_ready_in});
        @(posedge clk);
        #1;
        chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() > 0});
        cur = (exp_q.size() > 0) ? exp_q[0] : last_out;
        chk("iw_out", iw_out, cur.iw);
        chk("rs1_data_out", rs1_data_out, cur.a);
        chk("rs2_data_out", rs2_data_out, cur.b);
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    task automatic issue(input logic v, input logic [31:0] w);
        iw_valid_in = v; iw_in = w;
    endtask

    initial begin
        reset = 1'b0; out_ready_in = 1'b1;
        issue(1'b0, 32'h0); wb(1'b0, 5'd0, 32'h0);
        step(); step();
        reset = 1'b1;

        // write x5 then read it back with rs2 = x0
        wb(1'b1, 5'd5, 32'hDEAD_BEEF); step();
        wb(1'b0, 5'd0, 32'h0); issue(1'b1, mk(5'd5, 5'd0, 5'd1)); step();
        issue(1'b0, 32'h0); step();

        // same-cycle bypass on both operands
        wb(1'b1, 5'd7, 32'h0000_1234); issue(1'b1, mk(5'd7, 5'd7, 5'd2)); step();
        wb(1'b0, 5'd0, 32'h0); issue(1'b0, 32'h0); step();

        // x0 write ignored, x0 reads zero
        wb(1'b1, 5'd0, 32'hFFFF_FFFF); issue(1'b1, mk(5'd0, 5'd5, 5'd3)); step();
        wb(1'b0, 5'd0, 32'h0); issue(1'b1, mk(5'd0, 5'd0, 5'd3)); step();
        issue(1'b0, 32'h0); step();

        // stall with refresh of held rs2, pending instruction must wait
        out_ready_in = 1'b0;
        issue(1'b1, mk(5'd5, 5'd3, 5'd4)); step();
        issue(1'b1, mk(5'd3, 5'd5, 5'd6)); wb(1'b1, 5'd3, 32'h0000_A5A5); step();
        wb(1'b1, 5'd9, 32'h0909_0909); step();
        wb(1'b0, 5'd0, 32'h0); step();
        out_ready_in = 1'b1; step();
        issue(1'b0, 32'h0); step();

        // back-to-back stream of four, with writes to x31 and x1 mid-stream
        issue(1'b1, mk(5'd31, 5'd1, 5'd8)); wb(1'b1, 5'd31, 32'h3131_3131); step();
        issue(1'b1, mk(5'd3, 5'd31, 5'd8)); wb(1'b1, 5'd1, 32'h0000_0001); step();
        issue(1'b1, mk(5'd1, 5'd9, 5'd8)); wb(1'b0, 5'd0, 32'h0); step();
        issue(1'b1, mk(5'd7, 5'd5, 5'd8)); step();
        issue(1'b0, 32'h0); step(); step();

        // reset during a stall, with a blocked write in the reset cycle
        out_ready_in = 1'b0;
        issue(1'b1, mk(5'd5, 5'd7, 5'd10)); step();
        issue(1'b0, 32'h0); step();
        reset = 1'b0; wb(1'b1, 5'd5, 32'h5555_5555); step();
        reset = 1'b1; wb(1'b0, 5'd0, 32'h0); out_ready_in = 1'b1;
        issue(1'b1, mk(5'd5, 5'd31, 5'd11)); step();
        issue(1'b0, 32'h0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
